// File: rtl/dmem_line_responder_pkg.sv
// Shared types and widths for the single-line write-back data-memory responder.
package dmem_line_responder_pkg;

  localparam int BEAT_W     = 64;
  localparam int LINE_BEATS = 4;
  localparam int LINE_W     = BEAT_W * LINE_BEATS;
  localparam int OFF_W      = 5;
  localparam int TAG_W      = 32 - OFF_W;
  localparam int WORD_W     = 3;
  localparam int CNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_line_responder_if.sv
// CPU dmem request/response and burst memory signals; master = CPU + memory side, slave = responder.
interface dmem_line_responder_if;
  import dmem_line_responder_pkg::*;

  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/dmem_line_merge.sv
// Combinational word select from the line plus byte-masked write merge of one word into it.
module dmem_line_merge
  import dmem_line_responder_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WORD_W-1:0] word,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wmask,
  output logic [31:0]       rword,
  output logic [LINE_W-1:0] merged
);

  logic [7:0] word_base;
  logic [7:0] byte_base;
  logic [1:0] lane;

  always_comb begin
    word_base = {word, 5'd0};
    rword     = line[word_base +: 32];
    merged    = line;
    byte_base = 8'd0;
    lane      = 2'd0;
    for (int b = 0; b < 4; b++) begin
      lane      = 2'(b);
      byte_base = {word, lane, 3'd0};
      if (wmask[b]) merged[byte_base +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Single-entry write-back line buffer answering one outstanding dmem request; misses
// write back a dirty line then fill over the 4-beat burst port.
module dmem_line_responder
  import dmem_line_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dmem_line_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_t             state_q, state_d;
  logic [LINE_W-1:0]  line_q;
  logic [LINE_W-1:0]  merged;
  logic               valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   req_tag;
  logic [WORD_W-1:0]  req_word;
  logic [3:0]         req_wmask;
  logic [31:0]        req_wdata;
  logic               req_write;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rword;
  logic [7:0]         beat_base;
  logic               req_vld, hit, beat_ok;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.dmem_addr[1:0];
  assign req_vld   = (|bus.dmem_rmask) | (|bus.dmem_wmask);
  assign hit       = valid_q && (tag_q == req_tag);
  assign beat_base = {cnt_q, 6'd0};
  // Beats for any other line (e.g. another requester's burst) are not ours.
  assign beat_ok   = bus.bmem_rvalid && (bus.bmem_raddr == {req_tag, 5'd0});

  dmem_line_merge u_merge (
    .line   (line_q),
    .word   (req_word),
    .wdata  (req_wdata),
    .wmask  (req_wmask),
    .rword  (rword),
    .merged (merged)
  );

  always_comb begin
    state_d         = state_q;
    bus.dmem_resp   = 1'b0;
    bus.dmem_rdata  = 32'd0;
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_addr   = 32'd0;
    bus.bmem_wdata  = '0;
    case (state_q)
      IDLE:     if (req_vld) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          bus.dmem_resp  = 1'b1;
          bus.dmem_rdata = req_write ? 32'd0 : rword;
          state_d        = IDLE;
        end else if (dirty_q) begin
          state_d = WB;
        end else begin
          state_d = FILL_REQ;
        end
      end
      WB: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = {tag_q, 5'd0};
        bus.bmem_wdata = line_q[beat_base +: BEAT_W];
        if (bus.bmem_ready && cnt_q == LAST_BEAT) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = {req_tag, 5'd0};
        if (bus.bmem_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: if (beat_ok && cnt_q == LAST_BEAT) state_d = RESP;
      RESP: begin
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = req_write ? 32'd0 : rword;
        state_d        = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      valid_q   <= 1'b0;
      dirty_q   <= 1'b0;
      tag_q     <= '0;
      req_tag   <= '0;
      req_word  <= '0;
      req_wmask <= 4'd0;
      req_wdata <= 32'd0;
      req_write <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (req_vld) begin
          req_tag   <= bus.dmem_addr[31:OFF_W];
          req_word  <= bus.dmem_addr[OFF_W-1:2];
          req_wmask <= bus.dmem_wmask;
          req_wdata <= bus.dmem_wdata;
          req_write <= |bus.dmem_wmask;
        end
        LOOKUP: begin
          if (hit && req_write) begin
            line_q  <= merged;
            dirty_q <= 1'b1;
          end else if (!hit && !dirty_q) begin
            valid_q <= 1'b0;
          end
        end
        WB: if (bus.bmem_ready) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            dirty_q <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        FILL_WAIT: if (beat_ok) begin
          line_q[beat_base +: BEAT_W] <= bus.bmem_rdata;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            valid_q <= 1'b1;
            tag_q   <= req_tag;
          end
        end
        RESP: if (req_write) begin
          line_q  <= merged;
          dirty_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Bench for dmem_line_responder: directed scenarios plus random traffic against a line/memory model.
module tb_dmem_line_responder;
  import dmem_line_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_line_responder_if bus ();
  dmem_line_responder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [255:0] mem [logic [26:0]];
  logic         m_valid, m_dirty;
  logic [26:0]  m_tag;
  logic [255:0] m_line;

  logic         e_hit, e_wb;
  logic [31:0]  e_wb_addr, e_rdata;
  logic [255:0] e_wb_line;

  bit           o_resp, o_resp2, o_both, o_unstable, o_aborted, o_abort_zero;
  int           o_lat, o_last, o_nreads;
  logic [31:0]  o_rdata, o_raddr;
  logic [31:0]  wb_addr_q[$];
  logic [63:0]  wb_data_q[$];

  function automatic logic [255:0] mem_line(input logic [26:0] t);
    if (!mem.exists(t))
      mem[t] = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    return mem[t];
  endfunction

  // Reference: one cached line over a flat line-addressed memory, byte-granular writes.
  task automatic model_access(input logic [31:0] addr, input logic [3:0] wm, input logic [31:0] wd);
    logic [26:0] t;
    int w;
    t = addr[31:5];
    w = int'(addr[4:2]);
    e_hit = m_valid && (m_tag == t);
    e_wb = 1'b0; e_wb_addr = 32'd0; e_wb_line = '0;
    if (!e_hit) begin
      if (m_valid && m_dirty) begin
        e_wb = 1'b1; e_wb_addr = {m_tag, 5'd0}; e_wb_line = m_line;
        mem[m_tag] = m_line;
      end
      m_line = mem_line(t); m_tag = t; m_valid = 1'b1; m_dirty = 1'b0;
    end
    if (wm != 4'd0) begin
      for (int b = 0; b < 4; b++)
        if (wm[b]) m_line[w*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty = 1'b1;
      e_rdata = 32'd0;
    end else begin
      e_rdata = m_line[w*32 +: 32];
    end
  endtask

  // Drives one request and plays the burst memory until the response (or abort/timeout).
  task automatic run_access(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                            input logic [31:0] wd, input int stall_beat, input int bad_before,
                            input int abort_after);
    logic [63:0] beats[$];
    logic [63:0] held, ln_beat;
    logic [255:0] ln;
    logic [31:0] fill_addr;
    int cyc, delivered, wb_cnt, stalls;
    bit holding, bad_done;
    o_resp = 0; o_resp2 = 0; o_both = 0; o_unstable = 0; o_aborted = 0; o_abort_zero = 0;
    o_lat = 0; o_last = 0; o_nreads = 0; o_rdata = 32'd0; o_raddr = 32'd0;
    wb_addr_q.delete(); wb_data_q.delete();
    delivered = 0; wb_cnt = 0; stalls = 0; holding = 0; bad_done = 0; held = '0; fill_addr = '0;
    @(negedge clk);
    bus.dmem_addr = addr; bus.dmem_rmask = rm; bus.dmem_wmask = wm; bus.dmem_wdata = wd;
    @(negedge clk);
    bus.dmem_rmask = 4'd0; bus.dmem_wmask = 4'd0; bus.dmem_wdata = $urandom();
    cyc = 1;
    while (cyc < 300) begin
      if (bus.dmem_resp) begin
        o_resp = 1; o_lat = cyc; o_rdata = bus.dmem_rdata;
        break;
      end
      if (bus.bmem_read && bus.bmem_write) o_both = 1;
      bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
      if (abort_after > 0 && delivered == abort_after) begin
        rst = 1'b1;
        @(negedge clk);
        o_aborted = 1;
        o_abort_zero = !bus.dmem_resp && bus.dmem_rdata == 32'd0 && !bus.bmem_read &&
                       !bus.bmem_write && bus.bmem_addr == 32'd0 && bus.bmem_wdata == 64'd0;
        rst = 1'b0;
        bus.bmem_rvalid = 1'b1; bus.bmem_raddr = fill_addr; bus.bmem_rdata = beats.pop_front();
        @(negedge clk);
        bus.bmem_rvalid = 1'b0;
        break;
      end
      if (bus.bmem_write) begin
        if (holding && bus.bmem_wdata !== held) o_unstable = 1;
        if (wb_cnt == stall_beat && stalls < 2) begin
          stalls++; holding = 1; held = bus.bmem_wdata;
        end else begin
          bus.bmem_ready = 1'b1; holding = 0; wb_cnt++;
          wb_addr_q.push_back(bus.bmem_addr); wb_data_q.push_back(bus.bmem_wdata);
        end
      end else if (bus.bmem_read) begin
        if ($urandom_range(0, 2) != 0) begin
          bus.bmem_ready = 1'b1; o_nreads++; o_raddr = bus.bmem_addr; fill_addr = bus.bmem_addr;
          ln = mem_line(fill_addr[31:5]);
          for (int k = 0; k < 4; k++) begin
            ln_beat = ln[k*64 +: 64];
            beats.push_back(ln_beat);
          end
        end
      end else if (beats.size() > 0) begin
        if (!bad_done && delivered == bad_before) begin
          bus.bmem_rvalid = 1'b1; bus.bmem_raddr = fill_addr ^ 32'h0000_1000;
          bus.bmem_rdata = {$urandom(), $urandom()}; bad_done = 1;
        end else if ($urandom_range(0, 3) != 0) begin
          bus.bmem_rvalid = 1'b1; bus.bmem_raddr = fill_addr; bus.bmem_rdata = beats.pop_front();
          delivered++;
          if (beats.size() == 0) o_last = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.bmem_ready = 1'b0; bus.bmem_rvalid = 1'b0;
    if (o_resp) begin
      @(negedge clk);
      o_resp2 = bus.dmem_resp;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.dmem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", bus.dmem_resp); end
    checks++; if (bus.dmem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.dmem_rdata); end
    checks++; if ({bus.bmem_read, bus.bmem_write} !== 2'b00) begin errors++; $display("FAIL reset_rw: got %b want 00", {bus.bmem_read, bus.bmem_write}); end
    checks++; if (bus.bmem_addr !== 32'd0) begin errors++; $display("FAIL reset_baddr: got %h want 0", bus.bmem_addr); end
    checks++; if (bus.bmem_wdata !== 64'd0) begin errors++; $display("FAIL reset_bwdata: got %h want 0", bus.bmem_wdata); end
    rst = 1'b0;
    m_valid = 1'b0; m_dirty = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    mem[27'h80] = {64'h0123_4567_89AB_CDEF, 64'h5555_6666_7777_8888,
                   64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_0000_2222_0000};
    model_access(32'h0000_1008, 4'h0, 32'h0);
    run_access(32'h0000_1008, 4'hF, 4'h0, 32'h0, -1, -1, 0);
    checks++; if (o_resp !== 1'b1) begin errors++; $display("FAIL cold_resp: got %b want 1", o_resp); end
    checks++; if (o_rdata !== 32'hCCCC_DDDD) begin errors++; $display("FAIL cold_rdata: got %h want CCCCDDDD", o_rdata); end
    checks++; if (o_nreads !== 1 || o_raddr !== 32'h0000_1000) begin errors++; $display("FAIL cold_bread: got %0d reads addr %h want 1 at 00001000", o_nreads, o_raddr); end
    checks++; if (wb_data_q.size() !== 0) begin errors++; $display("FAIL cold_nowrite: got %0d write beats want 0", wb_data_q.size()); end
    checks++; if (o_lat !== o_last + 1) begin errors++; $display("FAIL cold_latency: got %0d want %0d", o_lat, o_last + 1); end
    checks++; if (o_resp2 !== 1'b0) begin errors++; $display("FAIL cold_pulse: resp still %b want 0", o_resp2); end
  endtask

  task automatic test_read_hit();
    model_access(32'h0000_100C, 4'h0, 32'h0);
    run_access(32'h0000_100C, 4'hF, 4'h0, 32'h0, -1, -1, 0);
    checks++; if (o_lat !== 1) begin errors++; $display("FAIL hit_latency: got %0d want 1", o_lat); end
    checks++; if (o_rdata !== 32'hAAAA_BBBB) begin errors++; $display("FAIL hit_rdata: got %h want AAAABBBB", o_rdata); end
    checks++; if (o_nreads !== 0 || wb_data_q.size() !== 0) begin errors++; $display("FAIL hit_nobmem: got %0d reads %0d writes want 0 0", o_nreads, wb_data_q.size()); end
  endtask

  task automatic test_byte_write();
    model_access(32'h0000_1008, 4'b0010, 32'h0000_5A00);
    run_access(32'h0000_1008, 4'h0, 4'b0010, 32'h0000_5A00, -1, -1, 0);
    checks++; if (o_lat !== 1 || o_rdata !== 32'd0) begin errors++; $display("FAIL bwr_resp: got lat %0d rdata %h want 1 0", o_lat, o_rdata); end
    model_access(32'h0000_1008, 4'h0, 32'h0);
    run_access(32'h0000_1008, 4'hF, 4'h0, 32'h0, -1, -1, 0);
    checks++; if (o_rdata !== 32'hCCCC_5ADD || o_lat !== 1) begin errors++; $display("FAIL bwr_readback: got %h lat %0d want CCCC5ADD 1", o_rdata, o_lat); end
  endtask

  task automatic test_dirty_evict();
    model_access(32'h0000_2000, 4'h0, 32'h0);
    run_access(32'h0000_2000, 4'hF, 4'h0, 32'h0, 1, -1, 0);
    checks++; if (wb_data_q.size() !== 4) begin errors++; $display("FAIL evict_nbeats: got %0d want 4", wb_data_q.size()); end
    for (int k = 0; k < wb_data_q.size(); k++) begin
      checks++; if (wb_addr_q[k] !== 32'h0000_1000 || wb_data_q[k] !== e_wb_line[k*64 +: 64]) begin
        errors++; $display("FAIL evict_beat%0d: got %h @%h want %h @00001000", k, wb_data_q[k], wb_addr_q[k], e_wb_line[k*64 +: 64]); end
    end
    if (wb_data_q.size() > 1) begin
      checks++; if (wb_data_q[1] !== 64'hAAAA_BBBB_CCCC_5ADD) begin errors++; $display("FAIL evict_beat1_val: got %h want AAAABBBBCCCC5ADD", wb_data_q[1]); end
    end
    checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL evict_hold: wdata changed under stall"); end
    checks++; if (o_nreads !== 1 || o_raddr !== 32'h0000_2000) begin errors++; $display("FAIL evict_fill: got %0d reads addr %h want 1 at 00002000", o_nreads, o_raddr); end
    checks++; if (o_resp !== 1'b1 || o_rdata !== e_rdata || o_both !== 1'b0) begin errors++; $display("FAIL evict_resp: got resp %b rdata %h both %b want 1 %h 0", o_resp, o_rdata, o_both, e_rdata); end
  endtask

  task automatic test_masks_bad_beat();
    model_access(32'h0000_4000, 4'h0, 32'h0);
    run_access(32'h0000_4000, 4'hF, 4'h0, 32'h0, -1, -1, 0);
    model_access(32'h0000_2004, 4'h1, 32'h1234_56E7);
    run_access(32'h0000_2004, 4'hF, 4'h1, 32'h1234_56E7, -1, 2, 0);
    checks++; if (o_resp !== 1'b1 || o_rdata !== 32'd0) begin errors++; $display("FAIL both_masks: got resp %b rdata %h want 1 0", o_resp, o_rdata); end
    checks++; if (o_lat !== o_last + 1 || wb_data_q.size() !== 0) begin errors++; $display("FAIL bad_beat_lat: got %0d wb %0d want %0d 0", o_lat, wb_data_q.size(), o_last + 1); end
    model_access(32'h0000_2004, 4'h0, 32'h0);
    run_access(32'h0000_2004, 4'hF, 4'h0, 32'h0, -1, -1, 0);
    checks++; if (o_rdata !== e_rdata || o_lat !== 1) begin errors++; $display("FAIL bad_beat_data: got %h lat %0d want %h 1", o_rdata, o_lat, e_rdata); end
  endtask

  task automatic test_reset_mid_fill();
    model_access(32'h0000_5010, 4'h0, 32'h0);
    run_access(32'h0000_5010, 4'hF, 4'h0, 32'h0, -1, -1, 2);
    m_valid = 1'b0; m_dirty = 1'b0;
    checks++; if (o_aborted !== 1'b1 || o_abort_zero !== 1'b1) begin errors++; $display("FAIL abort_outputs: aborted %b zero %b want 1 1", o_aborted, o_abort_zero); end
    model_access(32'h0000_5010, 4'h0, 32'h0);
    run_access(32'h0000_5010, 4'hF, 4'h0, 32'h0, -1, -1, 0);
    checks++; if (o_nreads !== 1 || o_raddr !== 32'h0000_5000 || wb_data_q.size() !== 0) begin errors++; $display("FAIL abort_refill: got %0d reads @%h wb %0d want 1 @00005000 0", o_nreads, o_raddr, wb_data_q.size()); end
    checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL abort_rdata: got %h want %h", o_rdata, e_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] lines [3];
    logic [31:0] a, wd;
    logic [3:0] rm, wm;
    lines[0] = 32'h0000_1000; lines[1] = 32'h0000_2000; lines[2] = 32'h0000_6000;
    for (int i = 0; i < 40; i++) begin
      a  = lines[$urandom_range(0, 2)] | (32'($urandom_range(0, 7)) << 2);
      rm = 4'($urandom_range(0, 15));
      wm = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
      wd = $urandom();
      model_access(a, wm, wd);
      run_access(a, rm, wm, wd, $urandom_range(0, 4) - 1, -1, 0);
      checks++; if (o_resp !== 1'b1 || o_rdata !== e_rdata) begin errors++; $display("FAIL rnd%0d_data: got resp %b rdata %h want 1 %h", i, o_resp, o_rdata, e_rdata); end
      checks++; if (o_lat !== (e_hit ? 1 : o_last + 1) || o_resp2 !== 1'b0) begin errors++; $display("FAIL rnd%0d_lat: got %0d pulse2 %b want %0d 0", i, o_lat, o_resp2, e_hit ? 1 : o_last + 1); end
      checks++; if (o_nreads !== (e_hit ? 0 : 1) || (!e_hit && o_raddr !== {a[31:5], 5'd0})) begin errors++; $display("FAIL rnd%0d_fill: got %0d reads @%h", i, o_nreads, o_raddr); end
      checks++; if (wb_data_q.size() !== (e_wb ? 4 : 0) || o_both !== 1'b0 || o_unstable !== 1'b0) begin errors++; $display("FAIL rnd%0d_wb: got %0d beats both %b unstable %b want %0d 0 0", i, wb_data_q.size(), o_both, o_unstable, e_wb ? 4 : 0); end
      for (int k = 0; k < wb_data_q.size(); k++) begin
        checks++; if (wb_data_q[k] !== e_wb_line[k*64 +: 64] || wb_addr_q[k] !== e_wb_addr) begin
          errors++; $display("FAIL rnd%0d_wbbeat%0d: got %h @%h want %h @%h", i, k, wb_data_q[k], wb_addr_q[k], e_wb_line[k*64 +: 64], e_wb_addr); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dmem_addr = 32'd0; bus.dmem_rmask = 4'd0; bus.dmem_wmask = 4'd0; bus.dmem_wdata = 32'd0;
    bus.bmem_ready = 1'b0; bus.bmem_raddr = 32'd0; bus.bmem_rdata = 64'd0; bus.bmem_rvalid = 1'b0;
    m_valid = 1'b0; m_dirty = 1'b0; m_tag = '0; m_line = '0;
    test_reset();
    test_cold_read();
    test_read_hit();
    test_byte_write();
    test_dirty_evict();
    test_masks_bad_beat();
    test_reset_mid_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Responder end of the CPU data-memory interface: accepts the writeback stage's single-outstanding dmem requests (rmask/wmask pulse) and returns dmem_rdata/dmem_resp.
- Backed by one 256-bit line buffer (single-entry write-back cache).
- Misses are serviced over the burst memory port: 4 x 64-bit beats, with an optional dirty write-back first.
- Sits between the CPU core and the burst memory model/arbiter.

Parameters:
- BEAT_W, 64, burst memory beat width in bits.
- LINE_BEATS, 4, beats per line; line = BEAT_W*LINE_BEATS = 256 bits (offset bits [4:0]).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- dmem_addr  in  32  request byte address; bits [1:0] ignored
- dmem_rmask  in  4  read byte mask; nonzero for one cycle = read request
- dmem_wmask  in  4  write byte mask; nonzero for one cycle = write request
- dmem_wdata  in  32  write data, byte lanes per wmask
- dmem_rdata  out  32  read word; valid only while dmem_resp=1
- dmem_resp  out  1  one-cycle completion pulse for reads and writes
- bmem_addr  out  32  line-aligned burst address ([4:0]=0)
- bmem_read  out  1  burst read request
- bmem_write  out  1  burst write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts read request / write beat this cycle
- bmem_raddr  in  32  line address of the returning read beat
- bmem_rdata  in  64  read beat data
- bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; line valid=0, dirty=0; beat counter=0.
  - dmem_resp=0, dmem_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
  - Reset mid-burst aborts the operation; beats arriving afterwards are ignored.
- Request capture:
  - Only in IDLE, when |dmem_rmask or |dmem_wmask.
  - Address, masks and wdata are registered.
  - If both masks are nonzero, the request is a write and rmask is ignored.
  - Requests outside IDLE are ignored (CPU contract: one outstanding).
- Tag/index: tag=addr[31:5], word=addr[4:2]. Hit = valid & tag match.
- FSM states: IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP.
  - IDLE -> LOOKUP on request.
  - LOOKUP, hit: read returns line word; write merges wdata bytes per wmask and sets dirty. dmem_resp=1 this cycle, then -> IDLE. Hit latency = request at cycle N, resp at N+1.
  - LOOKUP, miss & dirty -> WB. Miss & clean/invalid -> FILL_REQ.
  - WB: bmem_addr={old tag,5'b0}, bmem_write=1, bmem_wdata=beat[cnt].
    - cnt advances only on bmem_ready; beat is held while ready=0.
    - After beat LINE_BEATS-1 is accepted: dirty=0 -> FILL_REQ.
  - FILL_REQ: bmem_read=1, bmem_addr={new tag,5'b0}, held until bmem_ready, then -> FILL_WAIT.
  - FILL_WAIT: on bmem_rvalid with bmem_raddr==request line address, store beat[cnt] and cnt++.
    - rvalid with a mismatched raddr is dropped.
    - After the last beat: valid=1, tag updated, cnt=0 -> RESP.
  - RESP: same read/merge action as a hit. dmem_resp=1 for one cycle -> IDLE.
  - Clean-miss latency: resp one cycle after last beat + 1 (RESP registered).
- dmem_rdata = the full 32-bit word (byte extraction is done by the CPU); 0 when dmem_resp=0.
- Write with wmask partial (e.g. 4'b0100): only the addressed lanes change; other bytes are preserved.
- bmem_rvalid in IDLE/LOOKUP/WB/FILL_REQ is ignored.
- bmem_read and bmem_write are never asserted in the same cycle.
- Beat counter wraps from LINE_BEATS-1 to 0.

Decomposition:
- Shared package (rv32imc_types or a mem types package):
  - line/beat width constants.
  - Responder state enum.
  - Tag/offset field widths.
- One natural sub-module: dmem_line_merge (combinational word select plus byte-masked merge into the 256-bit line). The FSM and registers stay in the top module.

Test Plan:
- Cold read: rmask=4'hF at addr 0x0000_1008; memory line 0x1000 beats {64'h1111_0000_2222_0000, 64'hAAAA_BBBB_CCCC_DDDD, ...} -> bmem_read with bmem_addr=0x1000; after 4 rvalid beats, dmem_resp=1 with dmem_rdata=32'hCCCC_DDDD; no bmem_write.
- Read hit: second read at 0x100C -> dmem_resp exactly 1 cycle after the request, rdata=32'hAAAA_BBBB, no bmem activity.
- Byte write hit: wmask=4'b0010, wdata=32'h0000_5A00 at 0x1008 -> resp at N+1; subsequent read of 0x1008 returns 32'hCCCC_5ADD.
- Dirty eviction with backpressure: read 0x2000 after the dirty write; bmem_ready low for 2 cycles on beat 1 -> 4 write beats to 0x1000 in order, beat 1 = 64'hAAAA_BBBB_CCCC_5ADD held stable; then fill from 0x2000, then resp.
- Simultaneous masks and mismatched beat: rmask=4'hF & wmask=4'h1 -> treated as a write (rdata 0 on resp); an rvalid with raddr=0x3000 during fill of 0x2000 is dropped and the beat count is unchanged.
- Reset mid-fill: rst asserted after 2 beats -> all outputs 0 next cycle; the next read of the same line triggers a fresh bmem_read.
